// File: rtl/idex_hazard_unit.sv
// idex_hazard_unit: read-after-write hazard detection and bubble control for
// the ID/EX boundary of an in-order pipeline without forwarding. Tracks the
// destination registers of instructions in EX and MEM. It stalls IF/ID and
// zeroes ID/EX on a hazard, flushes on a taken branch, and freezes everything
// while memory is not ready.
module idex_hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        ex_branch_taken,
    input  logic        ext_stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_zero,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        P_RESET  = 3'd0,
        P_FREEZE = 3'd1,
        P_FLUSH  = 3'd2,
        P_STALL  = 3'd3,
        P_RUN    = 3'd4
    } prio_t;

    // In-flight writers. The register file is write-first, so a producer in
    // WB is already visible to ID. A WB slot could never match, so it is not
    // stored; the MEM entry simply retires on the next advance.
    logic       ex_valid_r;
    logic [4:0] ex_rd_r;
    logic       mem_valid_r;
    logic [4:0] mem_rd_r;

    logic [31:0] stall_cycles_r;
    logic [31:0] flush_cycles_r;

    logic  h1_s;
    logic  h2_s;
    logic  hazard_s;
    prio_t prio_s;

    // True when a valid in-flight writer targets source register rs (x0 never hazards)
    function automatic logic slot_hit(input logic valid, input logic [4:0] rd,
                                      input logic [4:0] rs);
        slot_hit = valid && (rd == rs) && (rs != REG_ZERO);
    endfunction

    // Hazard detection against the EX and MEM writers
    always_comb begin
        h1_s = id_valid && id_use_rs1 &&
               (slot_hit(ex_valid_r, ex_rd_r, id_rs1) || slot_hit(mem_valid_r, mem_rd_r, id_rs1));
        h2_s = id_valid && id_use_rs2 &&
               (slot_hit(ex_valid_r, ex_rd_r, id_rs2) || slot_hit(mem_valid_r, mem_rd_r, id_rs2));
        hazard_s = h1_s || h2_s;
    end

    // Priority resolution: reset, memory freeze, branch flush, hazard stall, run
    always_comb begin
        prio_s = P_RUN;
        if (rst) begin
            prio_s = P_RESET;
        end else if (ext_stall) begin
            prio_s = P_FREEZE;
        end else if (ex_branch_taken) begin
            prio_s = P_FLUSH;
        end else if (hazard_s) begin
            prio_s = P_STALL;
        end else begin
            prio_s = P_RUN;
        end
    end

    // Pipeline control outputs for the selected priority case
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_zero  = 1'b0;
        case (prio_s)
            P_RESET: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_zero  = 1'b1;
            end
            P_FREEZE: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b0;
                idex_zero  = 1'b0;
            end
            P_FLUSH: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
                idex_zero  = 1'b1;
            end
            P_STALL: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b0;
                idex_zero  = 1'b1;
            end
            P_RUN: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b0;
                idex_zero  = 1'b0;
            end
            default: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_zero  = 1'b1;
            end
        endcase
    end

    // Scoreboard advance: clear on reset, hold while frozen, otherwise shift
    // and load EX from ID (a bubble or an x0 write loads an invalid entry)
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r  <= 1'b0;
            ex_rd_r     <= 5'd0;
            mem_valid_r <= 1'b0;
            mem_rd_r    <= 5'd0;
        end else if (ext_stall) begin
            ex_valid_r  <= ex_valid_r;
            ex_rd_r     <= ex_rd_r;
            mem_valid_r <= mem_valid_r;
            mem_rd_r    <= mem_rd_r;
        end else begin
            mem_valid_r <= ex_valid_r;
            mem_rd_r    <= ex_rd_r;
            if (idex_zero) begin
                ex_valid_r <= 1'b0;
                ex_rd_r    <= 5'd0;
            end else begin
                ex_valid_r <= id_valid && id_regwrite && (id_rd != REG_ZERO);
                ex_rd_r    <= id_rd;
            end
        end
    end

    // Performance counters: stall and flush cycles, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
            flush_cycles_r <= 32'd0;
        end else begin
            if (prio_s == P_STALL) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (prio_s == P_FLUSH) begin
                flush_cycles_r <= flush_cycles_r + 32'd1;
            end else begin
                flush_cycles_r <= flush_cycles_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_cycles = flush_cycles_r;

endmodule

// File: tb/tb_idex_hazard_unit.sv
// Bench for idex_hazard_unit: each stimulus cycle pushes its expected control
// vector and counter values into a queue; a monitor pops and compares them
// mid-cycle, away from the rising edge.
module tb_idex_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [4:0]  id_rd = 5'd0;
    logic        id_regwrite = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        ext_stall = 1'b0;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_zero;
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;

    // {pc_write, ifid_write, ifid_flush, idex_zero}
    localparam logic [3:0] C_RST = 4'b0011;
    localparam logic [3:0] C_FRZ = 4'b0000;
    localparam logic [3:0] C_FLU = 4'b1111;
    localparam logic [3:0] C_HAZ = 4'b0001;
    localparam logic [3:0] C_RUN = 4'b1100;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur_e;
    logic [31:0] exp_sc = 32'd0;
    logic [31:0] exp_fc = 32'd0;
    int          checks = 0;
    int          errors = 0;

    idex_hazard_unit dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .ex_branch_taken (ex_branch_taken),
        .ext_stall       (ext_stall),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_zero       (idex_zero),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what it should produce
    task automatic step(input logic r, input logic xs, input logic br, input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw,
                        input logic [3:0] ctl, input logic cnt);
        exp_t e;
        @(negedge clk);
        rst = r; ext_stall = xs; ex_branch_taken = br; id_valid = v;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw;
        e.ctl = ctl; e.sc = exp_sc; e.fc = exp_fc; e.cnt = cnt;
        sb_q.push_back(e);
        // Counter effect of this cycle's rising edge
        if (ctl == C_RST) begin
            exp_sc = 32'd0;
            exp_fc = 32'd0;
        end else if (ctl == C_HAZ) begin
            exp_sc = exp_sc + 32'd1;
        end else if (ctl == C_FLU) begin
            exp_fc = exp_fc + 32'd1;
        end
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw,
                         input logic br, input logic xs, input logic [3:0] ctl);
        step(1'b0, xs, br, 1'b1, rs1, u1, rs2, u2, rd, rw, ctl, 1'b1);
    endtask

    task automatic idle(input logic [3:0] ctl);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ctl, 1'b1);
    endtask

    task automatic rand_reset(input logic cnt);
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), C_RST, cnt);
    endtask

    // Mid-cycle monitor: pop one expectation per cycle and compare
    always @(negedge clk) begin
        #2;
        if (sb_q.size() != 0) begin
            cur_e = sb_q.pop_front();
            check("ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_zero}, {28'd0, cur_e.ctl});
            if (cur_e.cnt) begin
                check("stall_cycles", stall_cycles, cur_e.sc);
                check("flush_cycles", flush_cycles, cur_e.fc);
            end
        end
    end

    // Bound the whole run
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with random inputs; counters are unknown until the first edge
        rand_reset(1'b0);
        rand_reset(1'b1);
        idle(C_RUN);

        // EX-distance hazard: two stall cycles, consumer issues on the third
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_HAZ);
        instr(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_HAZ);
        instr(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_RUN);

        // MEM-distance hazard on rs2: one stall cycle
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_HAZ);
        instr(5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_RUN);

        // x0 producer and x0 reader never stall; an unused source never stalls
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, C_RUN);
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd10, 1'b0, 5'd10, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_RUN);

        // Branch and hazard together: flush wins, only flush_cycles counts
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd12, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, C_FLU);
        idle(C_RUN);
        idle(C_RUN);

        // External stall inside a 2-cycle hazard; a branch while frozen is ignored
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd14, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_HAZ);
        instr(5'd14, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, C_FRZ);
        instr(5'd14, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, C_FRZ);
        instr(5'd14, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, C_FRZ);
        instr(5'd14, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_HAZ);
        instr(5'd14, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_RUN);

        // Mid-operation reset drops the scoreboard and the pending stall
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, C_RUN);
        instr(5'd15, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_HAZ);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, C_RST, 1'b1);
        instr(5'd15, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_RUN);

        // Counter wrap: preload stall_cycles to all ones, then one hazard cycle
        instr(5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, C_RUN);
        #3;
        dut.stall_cycles_r = 32'hFFFF_FFFF;
        exp_sc = 32'hFFFF_FFFF;
        instr(5'd9, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_HAZ);
        idle(C_RUN);
        idle(C_RUN);

        repeat (2) @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
